alu_shared_arbiter: RTL and testbench

Shares one registered 16-bit ALU between two requesters using valid/ready command and response handshakes. Arbitration is round-robin. The block latches the winning command, drives the ALU operand/function inputs, and waits a parameterised ALU latency. It then captures the result and the four ALU flags, and returns them to the requester that issued the command. It sits between the requester logic and the ALU instance; only one operation is in flight at a time.

---
 rtl/alu_shared_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_shared_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shared_arbiter.sv
// Round-robin front end that shares one registered 16-bit ALU between two requesters.
// Optional macro ALU_DIV0_CHECK_EN: short-circuits divide-by-zero commands with an error response.
module alu_shared_arbiter #(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [3:0]  req0_fun,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req1_fun,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_fun,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic        grant;
    logic        accept_ok;
    logic        accept;
    logic [3:0]  cnt;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic [3:0]  sel_fun;
    logic        pend;
    logic        is_div0;

    // With both requesting, the one that did not win last time goes next.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
    end

    assign accept_ok  = !rst && (state == IDLE) && !pend;
    assign req0_ready = accept_ok && req0_valid && !grant;
    assign req1_ready = accept_ok && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign sel_a   = grant ? req1_a   : req0_a;
    assign sel_b   = grant ? req1_b   : req0_b;
    assign sel_fun = grant ? req1_fun : req0_fun;

    assign busy = (state != IDLE) || pend;

`ifdef ALU_DIV0_CHECK_EN
    assign is_div0 = (sel_fun == 4'b0011) && (sel_b == 16'd0);
`else
    assign is_div0 = 1'b0;
    assign pend    = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            alu_fun    <= 4'b1111;
            rsp_data   <= 16'd0;
            rsp_flags  <= 4'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
`ifdef ALU_DIV0_CHECK_EN
            pend       <= 1'b0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ALU_DIV0_CHECK_EN
                    // Rejected divide: one holding cycle, then an error response without touching the ALU.
                    if (pend) begin
                        pend       <= 1'b0;
                        state      <= RESP;
                        rsp_data   <= 16'hFFFF;
                        rsp_flags  <= 4'b1000;
                        rsp_err    <= 1'b1;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                    end else
`endif
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        if (is_div0) begin
`ifdef ALU_DIV0_CHECK_EN
                            pend <= 1'b1;
`endif
                        end else begin
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_fun <= sel_fun;
                            cnt     <= 4'(ALU_LAT);
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        rsp_data   <= alu_out;
                        rsp_flags  <= alu_flags;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
`ifdef ALU_DIV0_CHECK_EN
                        rsp_err    <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (owner ? rsp1_ready : rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shared_arbiter.sv
// Scoreboard bench for alu_shared_arbiter: directed commands push expected responses,
// a monitor pops and compares on each response handshake.
module tb_alu_shared_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_fun, req1_fun;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err, busy;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_fun, alu_flags;

    alu_shared_arbiter #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    // Registered ALU stand-in (one register stage, fits within LAT=2).
    function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        case (f)
            4'b0000: return {a + b, 4'b1000};
            4'b0011: return (b == 16'd0) ? {16'hFFFF, 4'b1000} : {a / b, 4'b1000};
            4'b0100: return {a & b, 4'b0100};
            4'b1010: return {(a == b) ? 16'd1 : 16'd0, 4'b0010};
            4'b1011: return {(a > b) ? 16'd2 : ((a == b) ? 16'd1 : 16'd0), 4'b0010};
            4'b1110: return {a << 1, 4'b0001};
            default: return 20'd0;
        endcase
    endfunction

    always_ff @(posedge clk) {alu_out, alu_flags} <= alu_f(alu_a, alu_b, alu_fun);

    typedef struct {
        logic        p;
        logic [15:0] d;
        logic [3:0]  f;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ALU_DIV0_CHECK_EN
    localparam logic DIV0_ERR = 1'b1;
    localparam int   DIV0_LAT = 1;
`else
    localparam logic DIV0_ERR = 1'b0;
    localparam int   DIV0_LAT = LAT;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares on every response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid && rsp1_valid) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_both_valid: got 1 expected 0");
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                exp_t e;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_unexpected: got owner %0d data %h", rsp1_valid, rsp_data);
                end else begin
                    e = q.pop_front();
                    if (rsp1_valid !== e.p || rsp_data !== e.d || rsp_flags !== e.f || rsp_err !== e.e) begin
                        n_bad++;
                        $display("FAIL rsp: got owner %0d data %h flags %b err %b expected owner %0d data %h flags %b err %b",
                                 rsp1_valid, rsp_data, rsp_flags, rsp_err, e.p, e.d, e.f, e.e);
                    end
                end
            end
        end
    end

    task automatic push(input logic p, input logic [15:0] d, input logic [3:0] f, input logic e);
        exp_t x;
        x.p = p; x.d = d; x.f = f; x.e = e;
        q.push_back(x);
    endtask

    task automatic wait_ready(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                return;
            end
        end
        chk("ready_timeout", 1, 0);
    endtask

    task automatic issue(input int p, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                         input logic [15:0] d, input logic [3:0] f, input logic e, input bit do_push);
        bit ok;
        if (p == 0) begin req0_a = a; req0_b = b; req0_fun = fun; req0_valid = 1'b1; end
        else        begin req1_a = a; req1_b = b; req1_fun = fun; req1_valid = 1'b1; end
        wait_ready(p, ok);
        @(posedge clk);
        if (ok && do_push) push(p[0], d, f, e);
        #1;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic check_lat(input int p, input int exp);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p == 0) ? rsp0_valid : rsp1_valid) break;
            n++;
        end
        chk("latency", n, exp);
        chk("other_rsp_low", (p == 0) ? rsp1_valid : rsp0_valid, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rsp0_valid && !rsp1_valid && !busy) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("drain_timeout", 1, 0);
    endtask

    task automatic op(input int p, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                      input logic [15:0] d, input logic [3:0] f);
        issue(p, a, b, fun, d, f, 1'b0, 1'b1);
        check_lat(p, LAT);
        drain();
    endtask

    task automatic both_req(input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] f0,
                            input logic [15:0] d0, input logic [3:0] x0,
                            input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] f1,
                            input logic [15:0] d1, input logic [3:0] x1);
        bit ok;
        req0_a = a0; req0_b = b0; req0_fun = f0; req0_valid = 1'b1;
        req1_a = a1; req1_b = b1; req1_fun = f1; req1_valid = 1'b1;
        wait_ready(0, ok);
        chk("arb_winner_r1_low", req1_ready, 0);
        @(posedge clk);
        if (ok) push(1'b0, d0, x0, 1'b0);
        #1 req0_valid = 1'b0;
        wait_ready(1, ok);
        @(posedge clk);
        if (ok) push(1'b1, d1, x1, 1'b0);
        #1 req1_valid = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'h0FF0; req0_fun = 4'b0100;
        req1_valid = 1'b1; req1_a = 16'd9;    req1_b = 16'd3;    req1_fun = 4'b1011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_fun", alu_fun, 4'b1111);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_err}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Contention from reset, then again to confirm alternation.
        both_req(16'hF0F0, 16'h0FF0, 4'b0100, 16'h00F0, 4'b0100,
                 16'd9, 16'd3, 4'b1011, 16'd2, 4'b0010);
        both_req(16'd1, 16'd1, 4'b0000, 16'd2, 4'b1000,
                 16'hFFFF, 16'h00FF, 4'b0100, 16'h00FF, 4'b0100);

        op(0, 16'd7, 16'd5, 4'b0000, 16'd12, 4'b1000);

        // Response backpressure with a competing requester waiting.
        rsp0_ready = 1'b0;
        issue(0, 16'd1, 16'd2, 4'b0000, 16'd3, 4'b1000, 1'b0, 1'b1);
        req1_a = 16'd5; req1_b = 16'd6; req1_fun = 4'b0000; req1_valid = 1'b1;
        check_lat(0, LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp0_valid, 1);
            chk("bp_data", rsp_data, 16'd3);
            chk("bp_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1 rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_accept_in_resp", req1_ready, 0);
        @(posedge clk); #1;
        issue(1, 16'd5, 16'd6, 4'b0000, 16'd11, 4'b1000, 1'b0, 1'b1);
        check_lat(1, LAT);
        drain();

        // Reset one cycle into BUSY drops the transaction.
        issue(0, 16'd40, 16'd2, 4'b0000, 16'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_alu", {alu_a, alu_b, alu_fun}, {16'd0, 16'd0, 4'b1111});
        chk("midrst_rsp", {rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_err}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        end
        @(posedge clk); #1;
        op(1, 16'd100, 16'd23, 4'b0000, 16'd123, 4'b1000);

        // Shift / compare sweep.
        op(0, 16'h8001, 16'h0000, 4'b1110, 16'h0002, 4'b0001);
        op(1, 16'h1234, 16'h1234, 4'b1010, 16'h0001, 4'b0010);

        // Divide by zero.
        issue(0, 16'd100, 16'd0, 4'b0011, 16'hFFFF, 4'b1000, DIV0_ERR, 1'b1);
        check_lat(0, DIV0_LAT);
`ifdef ALU_DIV0_CHECK_EN
        chk("div0_alu_held", {alu_a, alu_b, alu_fun}, {16'h1234, 16'h1234, 4'b1010});
`else
        chk("div0_alu_issued", {alu_a, alu_b, alu_fun}, {16'd100, 16'd0, 4'b0011});
`endif
        drain();

        chk("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
